da_serial_mac: RTL

Parametrised bit-serial distributed-arithmetic (DA) inner-product engine computing y = sum over k of c_k * x_k for K fixed coefficients. It builds the 2^K-entry DA partial-sum table from a coefficient parameter and accumulates one input bit-plane per clock. A start/busy/done handshake frames each computation. It is the core of the team's DA FIR and filter-bank blocks and generalises the fixed 3-coefficient case table to any K, coefficient width and input width, with signed or unsigned inputs.

---
 rtl/da_serial_mac.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/da_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : da_serial_mac
// Brief    : Bit-serial distributed-arithmetic inner-product engine.
//            y = sum_k c_k * x_k over K fixed coefficients. The 2^K-entry
//            partial-sum table is built at elaboration, and one input
//            bit-plane is accumulated per clock.
// Revision : 1.0 - initial release
// ============================================================================
module da_serial_mac #(
   parameter int               K         = 3,
   parameter int               B         = 8,
   parameter int               CW        = 4,
   parameter logic [K*CW-1:0]  COEFS     = {4'sd1, 4'sd3, -4'sd2},
   parameter bit               SIGNED_IN = 1'b1,
   localparam int              OW        = CW + B + $clog2(K) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [K*B-1:0]    x_in,
   output logic              busy,
   output logic              done,
   output logic [OW-1:0]     y
);

   // LUT entries hold sums of up to K coefficients.
   localparam int c_LW = CW + $clog2(K);
   localparam int c_NW = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sum of the coefficients selected by the set bits of address a.
   function automatic logic signed [c_LW-1:0] lut_entry(input int unsigned a);
      logic signed [c_LW-1:0] s;
      logic signed [CW-1:0]   c;
      s = '0;
      for (int k = 0; k < K; k++) begin
         if (a[k]) begin
            c = COEFS[k*CW +: CW];
            s = s + {{(c_LW-CW){c[CW-1]}}, c};
         end
      end
      return s;
   endfunction

   logic signed [c_LW-1:0] w_lut [2**K];

   for (genvar a = 0; a < 2**K; a++) begin : g_lut
      localparam logic signed [c_LW-1:0] c_ENTRY = lut_entry(a);
      assign w_lut[a] = c_ENTRY;
   end

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_accept;
   logic [B-1:0]           r_x [K];
   logic [c_NW-1:0]        r_n;
   logic signed [OW-1:0]   r_acc;
   logic                   r_done;
   logic [OW-1:0]          r_y;

   logic [K-1:0]           w_addr;
   logic signed [c_LW-1:0] w_lut_sel;
   logic signed [OW-1:0]   w_lut_ext;
   logic signed [OW-1:0]   w_term;
   logic                   w_last;
   logic                   w_sign_plane;

   // Address bit k is the current LSB of input shift register k.
   always_comb begin
      w_addr = '0;
      for (int k = 0; k < K; k++) begin
         w_addr[k] = r_x[k][0];
      end
   end

   assign w_lut_sel    = w_lut[w_addr];
   assign w_lut_ext    = {{(OW-c_LW){w_lut_sel[c_LW-1]}}, w_lut_sel};
   assign w_term       = w_lut_ext <<< r_n;
   assign w_last       = (r_n == c_NW'(B-1));
   // The MSB plane of two's-complement inputs carries negative weight.
   assign w_sign_plane = SIGNED_IN && w_last;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a new job may be accepted from IDLE or DONE.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_RUN;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: load on accept, accumulate one bit-plane per RUN cycle,
   // publish the result when leaving DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < K; k++) begin
            r_x[k] <= '0;
         end
         r_n    <= '0;
         r_acc  <= '0;
         r_done <= 1'b0;
         r_y    <= '0;
      end else begin
         r_done <= (r_state == ST_DONE);
         if (r_state == ST_DONE) begin
            r_y <= r_acc;
         end
         if (w_accept) begin
            for (int k = 0; k < K; k++) begin
               r_x[k] <= x_in[k*B +: B];
            end
            r_n   <= '0;
            r_acc <= '0;
         end else if (r_state == ST_RUN) begin
            for (int k = 0; k < K; k++) begin
               r_x[k] <= r_x[k] >> 1;
            end
            r_n   <= r_n + c_NW'(1);
            r_acc <= w_sign_plane ? (r_acc - w_term) : (r_acc + w_term);
         end
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign y    = r_y;

endmodule
`default_nettype wire
